// File: rtl/alu_seq_responder.sv
// alu_seq_responder: handshaked 8-bit ALU responder; shifts iterate one bit per clock,
// all other ops complete in a single compute cycle.
module alu_seq_responder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc, alu_res, step_res;
    logic [SHAMT_W-1:0] cnt, shamt;
    logic [3:0]         op_q;
    logic               accept, done, alu_err, go_shift, last_step;

    assign shamt     = req_b[SHAMT_W-1:0];
    assign accept    = req_valid && req_ready;
    assign done      = rsp_valid && rsp_ready;
    assign go_shift  = (req_op >= 4'd2) && (req_op <= 4'd4) && (shamt != '0);
    assign last_step = cnt == SHAMT_W'(1);
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (req_op)
            4'd0: alu_res = req_a + req_b;
            4'd1: alu_res = req_a - req_b;
            4'd2: alu_res = req_a << shamt;
            4'd3: alu_res = $signed(req_a) >>> shamt;
            4'd4: alu_res = req_a >> shamt;
            4'd5: alu_res = req_a & req_b;
            4'd6: alu_res = req_a | req_b;
            4'd7: alu_res = req_a ^ req_b;
            4'd8: alu_res[0] = req_a == req_b;
            default: alu_err = 1'b1;
        endcase
    end

    // One bit position per cycle; arithmetic right replicates the sign bit
    assign step_res = (op_q == 4'd2) ? {acc[WIDTH-2:0], 1'b0} :
                      (op_q == 4'd3) ? {acc[WIDTH-1], acc[WIDTH-1:1]} :
                                       {1'b0, acc[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (go_shift ? SHIFT : RESP) : IDLE;
            SHIFT:   state_nxt = last_step ? RESP : SHIFT;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            op_q     <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                acc  <= req_a;
                cnt  <= shamt;
                op_q <= req_op;
                if (!go_shift) begin
                    rsp_data <= alu_res;
                    rsp_zero <= alu_res == '0;
                    rsp_err  <= alu_err;
                end
            end
            if (state == SHIFT) begin
                acc <= step_res;
                cnt <= cnt - SHAMT_W'(1);
                if (last_step) begin
                    rsp_data <= step_res;
                    rsp_zero <= step_res == '0;
                    rsp_err  <= 1'b0;
                end
            end
            if (done) ops_done <= ops_done + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: directed vectors plus a model-checked random run for alu_seq_responder.
module tb_alu_seq_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic [3:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;
    logic [15:0] ops_done;

    int total = 0;
    int bad = 0;
    int exp_ops = 0;

    alu_seq_responder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(b[2:0]);
        case (op)
            4'd0: return {1'b0, 8'(a + b)};
            4'd1: return {1'b0, 8'(a - b)};
            4'd2: return {1'b0, 8'(a << s)};
            4'd3: return {1'b0, 8'($signed(a) >>> s)};
            4'd4: return {1'b0, 8'(a >> s)};
            4'd5: return {1'b0, a & b};
            4'd6: return {1'b0, a | b};
            4'd7: return {1'b0, a ^ b};
            4'd8: return {1'b0, 7'd0, a == b};
            default: return {1'b1, 8'd0};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        chk("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        req_valid = 1'b0;
    endtask

    // Scrambles the request fields and idle rsp_ready while waiting; neither may matter
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            req_op = 4'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops++;
        chk("ops_done", 32'(ops_done), exp_ops);
        chk("req_ready_after_hs", req_ready, 1);
        chk("rsp_valid_after_hs", rsp_valid, 0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e,
                         input int exp_lat);
        int lat;
        send(op, a, b);
        wait_rsp(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_zero"}, rsp_zero, exp_d == 8'h00);
        chk({tag, "_err"}, rsp_err, exp_e);
        handshake();
    endtask

    initial begin
        int lat;
        int seen;
        logic [8:0] m;
        logic [3:0] op;
        logic [7:0] a, b;
        repeat (3) tick();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1);

        do_op("add", 4'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1);
        do_op("sub", 4'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 1);
        do_op("eq", 4'd8, 8'h3C, 8'h3C, 8'h01, 1'b0, 1);
        do_op("neq", 4'd8, 8'h3C, 8'h3D, 8'h00, 1'b0, 1);
        do_op("xor", 4'd7, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1);
        do_op("sra", 4'd3, 8'h90, 8'h03, 8'hF2, 1'b0, 4);
        do_op("srl", 4'd4, 8'h90, 8'h03, 8'h12, 1'b0, 4);
        do_op("sll2", 4'd2, 8'h81, 8'h0A, 8'h04, 1'b0, 3);
        do_op("sll0", 4'd2, 8'h5A, 8'h00, 8'h5A, 1'b0, 1);
        do_op("sll7", 4'd2, 8'h81, 8'hFF, 8'h80, 1'b0, 8);
        do_op("ill", 4'd9, 8'h12, 8'h34, 8'h00, 1'b1, 1);
        do_op("and", 4'd5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
        do_op("ill15", 4'd15, 8'hFF, 8'hFF, 8'h00, 1'b1, 1);
        do_op("or", 4'd6, 8'h50, 8'h0A, 8'h5A, 1'b0, 1);

        // Backpressure: result must stay put while the consumer stalls
        send(4'd0, 8'h03, 8'h04);
        wait_rsp(lat);
        chk("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_a = 8'($urandom);
            req_op = 4'd1;
            chk("bp_data", rsp_data, 8'h07);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_valid", rsp_valid, 1);
            tick();
        end
        req_valid = 1'b0;
        chk("bp_data_end", rsp_data, 8'h07);
        handshake();
        chk("bp_data_kept", rsp_data, 8'h07);

        // Reset in the third SHIFT cycle of a 7-step shift
        send(4'd2, 8'h01, 8'h07);
        chk("mid_busy", busy, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_ops", 32'(ops_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", seen, 0);
        chk("mid_ops_after", 32'(ops_done), 0);
        exp_ops = 0;

        for (int i = 0; i < 100; i++) begin
            op = 4'($urandom_range(0, 8));
            a = 8'($urandom);
            b = 8'($urandom);
            m = model(op, a, b);
            send(op, a, b);
            wait_rsp(lat);
            chk("rnd_lat", lat, (op >= 4'd2 && op <= 4'd4) ? 1 + int'(b[2:0]) : 1);
            chk("rnd_data", rsp_data, m[7:0]);
            chk("rnd_err", rsp_err, m[8]);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_stall_data", rsp_data, m[7:0]);
            end
            handshake();
        end
        chk("final_ops", 32'(ops_done), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
